// File: rtl/mem_burst_pkg.sv
// Shared types and default widths for the memory burst engine and its read checker.
package mem_burst_pkg;

    typedef enum logic {
        OP_WR = 1'b0,
        OP_RD = 1'b1
    } op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int LEN_W_DEF  = 8;
    localparam int RD_LAT_DEF = 1;

endpackage

// File: rtl/mem_burst_chk.sv
// Read-data checker: delays {valid, expected, addr} by RD_LAT edges to line up
// with memory data_out, then counts mismatches and latches the first bad address.
module mem_burst_chk
    import mem_burst_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              vld_in,
    input  logic [DATA_W-1:0] exp_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] rd_data,
    output logic [LEN_W:0]    err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              err_flag
);

    logic              vld_p  [RD_LAT];
    logic [DATA_W-1:0] exp_p  [RD_LAT];
    logic [ADDR_W-1:0] addr_p [RD_LAT];
    logic              mismatch;

    function automatic logic [LEN_W:0] sat_inc(input logic [LEN_W:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Stage 0 captures the beat on the same edge the memory samples rd_en.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < RD_LAT; k++) vld_p[k] <= 1'b0;
        end else begin
            vld_p[0] <= vld_in;
            for (int k = 1; k < RD_LAT; k++) vld_p[k] <= vld_p[k-1];
        end
    end

    always_ff @(posedge clk) begin
        exp_p[0]  <= exp_in;
        addr_p[0] <= addr_in;
        for (int k = 1; k < RD_LAT; k++) begin
            exp_p[k]  <= exp_p[k-1];
            addr_p[k] <= addr_p[k-1];
        end
    end

    // Compare stage: data_out is valid RD_LAT edges after the rd_en sample.
    assign mismatch = vld_p[RD_LAT-1] && (rd_data != exp_p[RD_LAT-1]);

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            err_cnt        <= '0;
            first_err_addr <= '0;
            err_flag       <= 1'b0;
        end else if (mismatch) begin
            err_cnt  <= sat_inc(err_cnt);
            err_flag <= 1'b1;
            if (err_cnt == '0) first_err_addr <= addr_p[RD_LAT-1];
        end
    end

endmodule

// File: rtl/mem_burst_engine.sv
// Burst command stage for the single-port memory: expands one command into
// back-to-back registered write or read beats and checks read data by pattern.
module mem_burst_engine
    import mem_burst_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_seed,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              done,
    output logic [LEN_W:0]    err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              err_flag
);

    localparam int DRN_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_e            state_q, state_nxt;
    logic [LEN_W-1:0]  cnt_q, cnt_nxt;
    logic [LEN_W-1:0]  len_q, len_nxt;
    logic [DRN_W-1:0]  drn_q, drn_nxt;
    logic [DATA_W-1:0] pat_q, pat_nxt;
    logic              wr_nxt, rd_nxt, done_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] din_nxt;
    logic              accept, rd_accept;

    assign accept    = cmd_valid && cmd_ready;
    assign rd_accept = accept && (op_e'(cmd_op) == OP_RD);

    // Next-state and next-port values; the port registers below present them one edge later.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        len_nxt   = len_q;
        drn_nxt   = drn_q;
        pat_nxt   = pat_q;
        wr_nxt    = 1'b0;
        rd_nxt    = 1'b0;
        done_nxt  = 1'b0;
        addr_nxt  = '0;
        din_nxt   = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    len_nxt  = cmd_len;
                    cnt_nxt  = '0;
                    pat_nxt  = cmd_seed;
                    addr_nxt = cmd_addr;
                    if (op_e'(cmd_op) == OP_RD) begin
                        state_nxt = READ;
                        rd_nxt    = 1'b1;
                    end else begin
                        state_nxt = WRITE;
                        wr_nxt    = 1'b1;
                        din_nxt   = cmd_seed;
                    end
                end
            end
            WRITE, READ: begin
                if (cnt_q == len_q) begin
                    if (state_q == WRITE) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = DRAIN;
                        drn_nxt   = '0;
                    end
                end else begin
                    cnt_nxt  = cnt_q + 1'b1;
                    pat_nxt  = pat_q + 1'b1;
                    addr_nxt = addr + 1'b1;
                    if (state_q == WRITE) begin
                        wr_nxt  = 1'b1;
                        din_nxt = pat_q + 1'b1;
                    end else begin
                        rd_nxt = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (drn_q == DRN_W'(RD_LAT - 1)) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end else begin
                    drn_nxt = drn_q + 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            drn_q     <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wr_en     <= 1'b0;
            rd_en     <= 1'b0;
            addr      <= '0;
            data_in   <= '0;
        end else begin
            state_q   <= state_nxt;
            drn_q     <= drn_nxt;
            cmd_ready <= (state_nxt == IDLE);
            busy      <= (state_nxt != IDLE);
            done      <= done_nxt;
            wr_en     <= wr_nxt;
            rd_en     <= rd_nxt;
            addr      <= addr_nxt;
            data_in   <= din_nxt;
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_nxt;
        len_q <= len_nxt;
        pat_q <= pat_nxt;
    end

    mem_burst_chk #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W),
        .RD_LAT (RD_LAT)
    ) u_chk (
        .clk            (clk),
        .rst            (rst),
        .clr            (rd_accept),
        .vld_in         (rd_en),
        .exp_in         (pat_q),
        .addr_in        (addr),
        .rd_data        (data_out),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr),
        .err_flag       (err_flag)
    );

endmodule
